// File: rtl/cdb_complete_arbiter_if.sv
// Result channels from the execute units into the completion arbiter, and the
// parallel CDB / ROB-completion ports leaving it.
interface cdb_complete_arbiter_if #(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2,
  parameter int PHYS_W  = 6,
  parameter int ROB_W   = 5,
  parameter int XLEN    = 32
);
  // Execute-unit side
  logic [NUM_FU-1:0]              fu_valid;
  logic [NUM_FU-1:0][PHYS_W-1:0]  fu_phys_reg;
  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_idx;
  logic [NUM_FU-1:0][XLEN-1:0]    fu_result;
  logic [NUM_FU-1:0][XLEN-1:0]    fu_rs2_value;
  logic [NUM_FU-1:0]              fu_take_branch;
  logic [NUM_FU-1:0]              fu_ready;

  // CDB broadcast / ROB completion side
  logic [NUM_CDB-1:0]             cdb_en;
  logic [NUM_CDB-1:0][PHYS_W-1:0] cdb_phys_reg;
  logic [NUM_CDB-1:0]             rob_complete_en;
  logic [NUM_CDB-1:0][ROB_W-1:0]  rob_complete_idx;
  logic [NUM_CDB-1:0][XLEN-1:0]   rob_result;
  logic [NUM_CDB-1:0][XLEN-1:0]   rob_rs2_value;
  logic [NUM_CDB-1:0]             rob_take_branch;

  // Producers of results and consumers of broadcasts
  modport master (
    output fu_valid, fu_phys_reg, fu_rob_idx, fu_result, fu_rs2_value, fu_take_branch,
    input  fu_ready,
    input  cdb_en, cdb_phys_reg, rob_complete_en, rob_complete_idx,
    input  rob_result, rob_rs2_value, rob_take_branch
  );

  // The arbiter itself
  modport slave (
    input  fu_valid, fu_phys_reg, fu_rob_idx, fu_result, fu_rs2_value, fu_take_branch,
    output fu_ready,
    output cdb_en, cdb_phys_reg, rob_complete_en, rob_complete_idx,
    output rob_result, rob_rs2_value, rob_take_branch
  );
endinterface

// File: rtl/cdb_complete_arbiter.sv
// Completion arbiter: one small FIFO per execute unit, and up to NUM_CDB
// results per cycle granted round-robin onto the CDB / ROB-completion ports.
module cdb_complete_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 2,
  parameter int BUF_DEPTH = 2,
  parameter int PHYS_W    = 6,
  parameter int ROB_W     = 5,
  parameter int XLEN      = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  input logic                  squash,
  cdb_complete_arbiter_if.slave bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);

  typedef struct packed {
    logic [PHYS_W-1:0] phys_reg;
    logic [ROB_W-1:0]  rob_idx;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   rs2_value;
    logic              take_branch;
  } entry_t;

  entry_t           mem   [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0] head  [NUM_FU];
  logic [PTR_W-1:0] tail  [NUM_FU];
  logic [CNT_W-1:0] count [NUM_FU];
  logic [FU_W-1:0]  rr_ptr;
  logic [FU_W-1:0]  rr_next;

  logic [NUM_FU-1:0]  enq;
  logic [NUM_FU-1:0]  grant;
  logic [NUM_CDB-1:0] port_vld;
  logic [FU_W-1:0]    port_fu [NUM_CDB];

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready reflects registered occupancy only; a flushing or resetting cycle accepts nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bus.fu_ready = '0;
    enq          = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_ready[i] = (count[i] < FULL_CNT);
      enq[i]          = bus.fu_valid[i] && (count[i] < FULL_CNT) && reset_n && !squash;
    end
  end

  // Scan from rr_ptr upward and hand the first NUM_CDB non-empty FIFOs to ports 0,1,...
  always_comb begin
    logic [FU_W-1:0] fu;
    int              slot;
    fu       = '0;
    slot     = 0;
    grant    = '0;
    port_vld = '0;
    rr_next  = rr_ptr;
    for (int p = 0; p < NUM_CDB; p++) port_fu[p] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      fu = FU_W'((int'(rr_ptr) + k) % NUM_FU);
      if (!squash && (count[fu] != '0) && (slot < NUM_CDB)) begin
        grant[fu] = 1'b1;
        for (int p = 0; p < NUM_CDB; p++) begin
          if (p == slot) begin
            port_vld[p] = 1'b1;
            port_fu[p]  = fu;
          end
        end
        slot    = slot + 1;
        rr_next = FU_W'((int'(fu) + 1) % NUM_FU);
      end
    end
  end

  // Drive each granted port from its FIFO head; idle ports present all zeros.
  always_comb begin
    entry_t head_e;
    head_e               = '0;
    bus.cdb_en           = '0;
    bus.cdb_phys_reg     = '0;
    bus.rob_complete_en  = '0;
    bus.rob_complete_idx = '0;
    bus.rob_result       = '0;
    bus.rob_rs2_value    = '0;
    bus.rob_take_branch  = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (port_vld[p]) begin
        head_e                  = mem[port_fu[p]][head[port_fu[p]]];
        bus.cdb_en[p]           = 1'b1;
        bus.rob_complete_en[p]  = 1'b1;
        bus.cdb_phys_reg[p]     = head_e.phys_reg;
        bus.rob_complete_idx[p] = head_e.rob_idx;
        bus.rob_result[p]       = head_e.result;
        bus.rob_rs2_value[p]    = head_e.rs2_value;
        bus.rob_take_branch[p]  = head_e.take_branch;
      end
    end
  end

  // Payload write at the tail of each accepting FIFO.
  always_ff @(posedge clock) begin
    // NOTE: payload storage has no reset; the occupancy counts alone decide which slots are live.
    for (int i = 0; i < NUM_FU; i++) begin
      if (enq[i]) begin
        mem[i][tail[i]] <= '{bus.fu_phys_reg[i], bus.fu_rob_idx[i], bus.fu_result[i],
                             bus.fu_rs2_value[i], bus.fu_take_branch[i]};
      end
    end
  end

  // FIFO pointers, occupancy and round-robin pointer; reset and squash drop all queued work.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (!reset_n || squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (enq[i])   tail[i] <= bump(tail[i]);
        if (grant[i]) head[i] <= bump(head[i]);
        case ({enq[i], grant[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
      rr_ptr <= rr_next;
    end
  end
endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Directed bench for cdb_complete_arbiter: a 2-port instance for single, wrap,
// burst, squash and reset scenarios, and a 1-port instance for fairness and
// backpressure. Expected broadcasts are queued as results are offered and
// popped as ports fire.
module tb_cdb_complete_arbiter;
  typedef struct packed {
    logic [5:0]  phys;
    logic [4:0]  rob;
    logic [31:0] res;
    logic [31:0] rs2;
    logic        tb;
  } ent_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic squash  = 1'b0;
  logic squash1 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  ent_t sb0 [$];
  ent_t sb1 [4][$];

  cdb_complete_arbiter_if #(.NUM_FU(4), .NUM_CDB(2), .PHYS_W(6), .ROB_W(5), .XLEN(32)) b0 ();
  cdb_complete_arbiter_if #(.NUM_FU(4), .NUM_CDB(1), .PHYS_W(6), .ROB_W(5), .XLEN(32)) b1 ();

  cdb_complete_arbiter #(.NUM_FU(4), .NUM_CDB(2), .BUF_DEPTH(2), .PHYS_W(6), .ROB_W(5), .XLEN(32))
    dut0 (.clock(clock), .reset_n(reset_n), .squash(squash), .bus(b0));
  cdb_complete_arbiter #(.NUM_FU(4), .NUM_CDB(1), .BUF_DEPTH(2), .PHYS_W(6), .ROB_W(5), .XLEN(32))
    dut1 (.clock(clock), .reset_n(reset_n), .squash(squash1), .bus(b1));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic ent_t mk(input int seed);
    ent_t e;
    e.phys = 6'(seed);
    e.rob  = 5'(seed * 3);
    e.res  = 32'hA500_0000 + 32'(seed) * 32'h0001_0101;
    e.rs2  = ~e.res;
    e.tb   = seed[0];
    return e;
  endfunction

  // FU-f result number n: tag carries the FU in its top bits and n+1 below.
  function automatic ent_t mk1(input int f, input int n);
    ent_t e;
    e.phys = {2'(f), 4'(n + 1)};
    e.rob  = 5'(f * 8 + n);
    e.res  = 32'hB000_0000 | (32'(f) << 16) | 32'(n);
    e.rs2  = e.res ^ 32'h0000_FFFF;
    e.tb   = 1'(n + f);
    return e;
  endfunction

  task automatic drive0(input int f, input ent_t e);
    b0.fu_valid[f]       = 1'b1;
    b0.fu_phys_reg[f]    = e.phys;
    b0.fu_rob_idx[f]     = e.rob;
    b0.fu_result[f]      = e.res;
    b0.fu_rs2_value[f]   = e.rs2;
    b0.fu_take_branch[f] = e.tb;
  endtask

  task automatic drive1(input int f, input ent_t e);
    b1.fu_valid[f]       = 1'b1;
    b1.fu_phys_reg[f]    = e.phys;
    b1.fu_rob_idx[f]     = e.rob;
    b1.fu_result[f]      = e.res;
    b1.fu_rs2_value[f]   = e.rs2;
    b1.fu_take_branch[f] = e.tb;
  endtask

  function automatic ent_t obs0(input int p);
    return ent_t'{b0.cdb_phys_reg[p], b0.rob_complete_idx[p], b0.rob_result[p],
                  b0.rob_rs2_value[p], b0.rob_take_branch[p]};
  endfunction

  function automatic ent_t obs1();
    return ent_t'{b1.cdb_phys_reg[0], b1.rob_complete_idx[0], b1.rob_result[0],
                  b1.rob_rs2_value[0], b1.rob_take_branch[0]};
  endfunction

  task automatic do_reset();
    reset_n     = 1'b0;
    squash      = 1'b0;
    b0.fu_valid = '0;
    b1.fu_valid = '0;
    step();
    reset_n = 1'b1;
  endtask

  // Two-port instance: enables must match exp_en; active ports pop the scoreboard in port order.
  task automatic mon0(input string name, input logic [1:0] exp_en);
    ent_t e;
    check({name, "_cdb_en"}, 128'(b0.cdb_en), 128'(exp_en));
    check({name, "_rob_en"}, 128'(b0.rob_complete_en), 128'(exp_en));
    for (int p = 0; p < 2; p++) begin
      if (exp_en[p]) begin
        check($sformatf("%s_p%0d_expected", name, p), 128'(sb0.size() != 0), 128'(1'b1));
        if (sb0.size() != 0) begin
          e = sb0.pop_front();
          check($sformatf("%s_p%0d_payload", name, p), 128'(obs0(p)), 128'(e));
        end
      end else begin
        check($sformatf("%s_p%0d_idle_zero", name, p), 128'(obs0(p)), 128'(0));
      end
    end
  endtask

  // One-port instance: the next grant goes to the first FU at or after rr_m with work queued.
  task automatic mon1(input string name, inout int rr_m);
    int   f;
    ent_t e;
    f = -1;
    for (int j = 0; j < 4; j++) begin
      if (f < 0 && sb1[(rr_m + j) % 4].size() != 0) f = (rr_m + j) % 4;
    end
    if (f < 0) begin
      check({name, "_idle_en"}, 128'({b1.cdb_en, b1.rob_complete_en}), 128'(0));
      check({name, "_idle_zero"}, 128'(obs1()), 128'(0));
    end else begin
      e = sb1[f].pop_front();
      check({name, "_en"}, 128'({b1.cdb_en, b1.rob_complete_en}), 128'(2'b11));
      check($sformatf("%s_fu%0d_payload", name, f), 128'(obs1()), 128'(e));
      rr_m = (f + 1) % 4;
    end
  endtask

  // Active FUs offer every cycle, holding a result until it is accepted; then drain.
  task automatic run1(input string name, input logic [3:0] mask, input int ncyc,
                      input logic [3:0] ready_c2);
    int   seq [4];
    int   rr_m;
    logic seen_full0;
    int   left;
    do_reset();
    for (int f = 0; f < 4; f++) seq[f] = 0;
    rr_m       = 0;
    seen_full0 = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == 2) check({name, "_ready_c2"}, 128'(b1.fu_ready), 128'(ready_c2));
      if (!b1.fu_ready[0]) seen_full0 = 1'b1;
      for (int f = 0; f < 4; f++) begin
        if (mask[f]) begin
          drive1(f, mk1(f, seq[f]));
          if (b1.fu_ready[f]) begin
            sb1[f].push_back(mk1(f, seq[f]));
            seq[f]++;
          end
        end
      end
      #1;
      if (k == 0) check({name, "_c0_en"}, 128'(b1.cdb_en), 128'(0));
      else        mon1(name, rr_m);
      step();
    end
    b1.fu_valid = '0;
    for (int k = 0; k < 24; k++) begin
      left = 0;
      for (int f = 0; f < 4; f++) left += sb1[f].size();
      if (left == 0) break;
      #1;
      mon1({name, "_drain"}, rr_m);
      step();
    end
    left = 0;
    for (int f = 0; f < 4; f++) left += sb1[f].size();
    check({name, "_all_broadcast"}, 128'(left), 128'(0));
    check({name, "_fu0_backpressured"}, 128'(seen_full0), 128'(1'b1));
    #1;
    mon1({name, "_quiet"}, rr_m);
    for (int f = 0; f < 4; f++) sb1[f].delete();
  endtask

  initial begin
    ent_t e;
    b0.fu_valid = '0; b0.fu_phys_reg = '0; b0.fu_rob_idx = '0;
    b0.fu_result = '0; b0.fu_rs2_value = '0; b0.fu_take_branch = '0;
    b1.fu_valid = '0; b1.fu_phys_reg = '0; b1.fu_rob_idx = '0;
    b1.fu_result = '0; b1.fu_rs2_value = '0; b1.fu_take_branch = '0;

    // Reset state
    do_reset();
    #1;
    mon0("rst", 2'b00);
    check("rst_ready0", 128'(b0.fu_ready), 128'(4'hF));
    check("rst_ready1", 128'(b1.fu_ready), 128'(4'hF));
    check("rst_rr", 128'(dut0.rr_ptr), 128'(0));
    check("rst_idle1", 128'(obs1()), 128'(0));

    // Single result from FU2
    e = '{phys: 6'd7, rob: 5'd3, res: 32'hDEADBEEF, rs2: 32'h0000_1234, tb: 1'b1};
    drive0(2, e);
    sb0.push_back(e);
    #1 mon0("single_c0", 2'b00);
    step(); b0.fu_valid = '0;
    #1 mon0("single_c1", 2'b01);
    step();
    #1 mon0("single_c2", 2'b00);
    check("single_rr", 128'(dut0.rr_ptr), 128'(3));

    // Scan wraps: from rr_ptr=3, FU3 lands on port 0 and FU0 on port 1
    drive0(0, mk(20)); drive0(3, mk(23));
    sb0.push_back(mk(23)); sb0.push_back(mk(20));
    step(); b0.fu_valid = '0;
    #1 mon0("wrap_c1", 2'b11);
    step();
    #1 mon0("wrap_c2", 2'b00);
    check("wrap_rr", 128'(dut0.rr_ptr), 128'(1));

    // Burst on all four FUs drains two per cycle in FU order
    do_reset();
    for (int f = 0; f < 4; f++) begin
      drive0(f, mk(10 + f));
      sb0.push_back(mk(10 + f));
    end
    #1 mon0("burst_c0", 2'b00);
    step(); b0.fu_valid = '0;
    #1 mon0("burst_c1", 2'b11);
    step();
    #1 mon0("burst_c2", 2'b11);
    step();
    #1 mon0("burst_c3", 2'b00);
    check("burst_drained", 128'(sb0.size()), 128'(0));

    // Squash with three entries buffered and FU1 offering in the squash cycle
    do_reset();
    for (int f = 0; f < 3; f++) drive0(f, mk(40 + f));
    #1 mon0("sq_c0", 2'b00);
    step(); b0.fu_valid = '0;
    squash = 1'b1;
    drive0(1, mk(50));
    #1 mon0("sq_c1", 2'b00);
    step(); b0.fu_valid = '0;
    squash = 1'b0;
    #1 mon0("sq_c2", 2'b00);
    check("sq_ready", 128'(b0.fu_ready), 128'(4'hF));
    check("sq_rr", 128'(dut0.rr_ptr), 128'(0));
    step();
    #1 mon0("sq_c3", 2'b00);
    drive0(3, mk(55));
    sb0.push_back(mk(55));
    step(); b0.fu_valid = '0;
    #1 mon0("sq_c4", 2'b01);

    // Reset mid-burst; the dropped FU2 offer must never appear
    step();
    for (int f = 0; f < 4; f++) drive0(f, mk(60 + f));
    #1 mon0("rstb_c0", 2'b00);
    step(); b0.fu_valid = '0;
    reset_n = 1'b0;
    drive0(2, mk(70));
    step(); b0.fu_valid = '0;
    reset_n = 1'b1;
    #1 mon0("rstb_c2", 2'b00);
    check("rstb_ready", 128'(b0.fu_ready), 128'(4'hF));
    check("rstb_rr", 128'(dut0.rr_ptr), 128'(0));
    drive0(1, mk(71));
    sb0.push_back(mk(71));
    step(); b0.fu_valid = '0;
    #1 mon0("rstb_c3", 2'b01);
    step();
    #1 mon0("rstb_c4", 2'b00);
    check("rstb_drained", 128'(sb0.size()), 128'(0));

    // Single-port fairness (FU0..2) and backpressure (FU0..1)
    run1("fair", 4'b0111, 18, 4'b1001);
    run1("bp", 4'b0011, 20, 4'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected $finish before 100000");
    $fatal(1, "watchdog expired");
  end
endmodule
